matrix_crc_checker: RTL
=======================

MATRIX_CRC_CHECKER -- requirements
Module: matrix_crc_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: number of consecutive matching words required to declare lock.
REQ-002 Parameter UNLOCK_CNT, default 3: number of consecutive mismatching words while locked that cause loss of lock.
REQ-003 Parameter ERR_W, default 16: width of the error counter.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  reset is synchronous and active-high.
REQ-006 cfg_we  in  1  matrix row write strobe.
REQ-007 cfg_addr  in  3  row index 0..7.
REQ-008 cfg_data  in  8  row value.
REQ-009 rx_valid  in  1  rx_data qualifier, one word per asserted cycle.
REQ-010 rx_data  in  8  received generator state word.
REQ-011 err_clr  in  1  synchronous clear of err_count.
REQ-012 locked  out  1  checker locked to the sequence.
REQ-013 err_pulse  out  1  one-cycle flag for a mismatched word while locked.
REQ-014 err_count  out  ERR_W  saturating mismatch count.
REQ-015 expected  out  8  current predicted next word.

Function
REQ-016 Next-state function M(x) SHALL be the XOR of row_i over all i where x[i]=1; M(x)=0 when x=0.
REQ-017 cfg_we SHALL write cfg_data into row[cfg_addr] at the clock edge; the new row is used from the next cycle onward.
REQ-018 FSM states SHALL be SEED, VERIFY, LOCKED; no state change or register update occurs on cycles with rx_valid=0, except via cfg_we or err_clr.
REQ-019 SEED: on rx_valid with rx_data!=0, expected<=M(rx_data), run count<=0, go VERIFY; rx_data=0 is ignored (stay SEED).
REQ-020 VERIFY: on rx_valid with rx_data==expected, expected<=M(rx_data) and run count increments; on reaching LOCK_CNT, go LOCKED and clear run count.
REQ-021 VERIFY: on rx_valid with mismatch, reseed from the word: expected<=M(rx_data), run count<=0, stay VERIFY; no error is counted (go SEED if rx_data=0).
REQ-022 LOCKED (flywheel): on every rx_valid, expected<=M(expected), regardless of rx_data.
REQ-023 LOCKED mismatch SHALL assert err_pulse for exactly the cycle after the offending word, increment err_count, and increment bad count.
REQ-024 LOCKED match SHALL clear bad count; on bad count reaching UNLOCK_CNT, go SEED, and locked deasserts the following cycle.
REQ-025 locked SHALL be 1 exactly while the FSM is in LOCKED; it is registered, asserting the cycle after the LOCK_CNT-th matching word.
REQ-026 cfg_we while in VERIFY or LOCKED SHALL force SEED and clear run/bad counts in the same edge.
REQ-027 err_count SHALL saturate at 2^ERR_W-1.
REQ-028 err_clr coincident with an error increment: clear wins, err_count=0.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset SHALL set state=SEED, all rows=8'h00, expected=8'h00, run/bad counts=0, locked=0, err_pulse=0, err_count=0.
REQ-031 reset asserted mid-operation SHALL override cfg_we, rx_valid and err_clr in that cycle.

Configuration
REQ-032 Macro MATRIX_CRC_CHECKER_ERR_COUNT_EN defined: err_count and err_clr behave per REQ-023, REQ-027, REQ-028.
REQ-033 Macro not defined: counter logic SHALL be absent, err_count driven constant 0, err_clr ignored; err_pulse and lock behaviour are unchanged.

Verification
(Matrix for all cases: row_i = 1<<(i+1) for i=0..6, row_7 = 8'h1D; sequence from 01: 02 04 08 10 20 40 80 1D 3A.)
REQ-034 Lock: feed 01,02,04,08,10 -> locked=1 the cycle after word 10; expected=20; err_count=0.
REQ-035 Single error: when locked, feed 20,FF,80 -> one err_pulse after FF, err_count=1, locked remains 1, expected=1D after 80.
REQ-036 Unlock: when locked, feed three wrong words AA,AA,AA -> err_count=3, locked=0 after third; then feed 01,02,04,08,10 -> relock.
REQ-037 Seed/reseed: feed 00,00,01,55,AA -> zeros ignored, 55 causes reseed with expected=M(55)=AA, no err_pulse, locked=0.
REQ-038 Config and reset mid-lock: cfg_we row 7 = 8'h1D while locked -> locked=0 next cycle; assert reset while locked with err_count=5 and err_clr=1 -> all outputs 0, rows 0.
REQ-039 Saturation/clear: with ERR_W=2 and locked, feed 5 mismatches using UNLOCK_CNT=8 -> err_count=3; err_clr with a coincident error -> err_count=0.

Source files
------------

// File: rtl/matrix_crc_checker.sv
// Matrix-sequence checker: seeds from the received words, verifies them, then flywheels while locked.
// Optional error counter is enabled by defining MATRIX_CRC_CHECKER_ERR_COUNT_EN.
module matrix_crc_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             cfg_we_i,
    input  logic [2:0]       cfg_addr_i,
    input  logic [7:0]       cfg_data_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             err_clr_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [7:0]       expected_o
);
    // state   | meaning
    // SEED    | waiting for a non-zero word to start prediction
    // VERIFY  | counting consecutive correct predictions
    // LOCKED  | flywheel on own prediction, counting consecutive misses
    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(UNLOCK_CNT - 1);

    state_t           state_q;
    logic [7:0]       rows_q [8];
    logic [7:0]       expected_q;
    logic [RUN_W-1:0] run_q;
    logic [BAD_W-1:0] bad_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [7:0]       m_rx;
    logic [7:0]       m_exp;
    logic             err_hit;

    always_comb begin
        m_rx  = '0;
        m_exp = '0;
        for (int i = 0; i < 8; i++) begin
            if (rx_data_i[i])  m_rx  = m_rx ^ rows_q[i];
            if (expected_q[i]) m_exp = m_exp ^ rows_q[i];
        end
    end

    // A row write in VERIFY/LOCKED pre-empts the received word, so it cannot count as an error.
    assign err_hit = rx_valid_i && !cfg_we_i && (state_q == LOCKED) && (rx_data_i != expected_q);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= SEED;
            for (int i = 0; i < 8; i++) rows_q[i] <= '0;
            expected_q  <= '0;
            run_q       <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_hit;
            if (cfg_we_i) rows_q[cfg_addr_i] <= cfg_data_i;
            if (cfg_we_i && state_q != SEED) begin
                state_q  <= SEED;
                run_q    <= '0;
                bad_q    <= '0;
                locked_q <= 1'b0;
            end else if (rx_valid_i) begin
                unique case (state_q)
                    SEED: begin
                        if (rx_data_i != 8'h00) begin
                            expected_q <= m_rx;
                            run_q      <= '0;
                            state_q    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        expected_q <= m_rx;
                        if (rx_data_i == expected_q) begin
                            if (run_q == RUN_LAST) begin
                                run_q    <= '0;
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                run_q <= run_q + 1'b1;
                            end
                        end else begin
                            run_q <= '0;
                            if (rx_data_i == 8'h00) state_q <= SEED;
                        end
                    end
                    LOCKED: begin
                        expected_q <= m_exp;
                        if (err_hit) begin
                            if (bad_q == BAD_LAST) begin
                                bad_q    <= '0;
                                state_q  <= SEED;
                                locked_q <= 1'b0;
                            end else begin
                                bad_q <= bad_q + 1'b1;
                            end
                        end else begin
                            bad_q <= '0;
                        end
                    end
                    default: state_q <= SEED;
                endcase
            end
        end
    end

`ifdef MATRIX_CRC_CHECKER_ERR_COUNT_EN
    logic [ERR_W-1:0] err_count_q;

    always_ff @(posedge clock_i) begin
        if (reset_i || err_clr_i) begin
            err_count_q <= '0;
        end else if (err_hit && err_count_q != {ERR_W{1'b1}}) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign err_count_o = err_count_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_count_o    = '0;
`endif

    assign locked_o    = locked_q;
    assign err_pulse_o = err_pulse_q;
    assign expected_o  = expected_q;
endmodule
